// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared constants and mask helper for the write-back arbiter
package regfile_wb_arbiter_pkg;
  localparam int   REG_COUNT = 16;
  localparam logic REQ_A     = 1'b0;
  localparam logic REQ_B     = 1'b1;
  function automatic logic [REG_COUNT-1:0] onehot16(input logic [3:0] addr);
    return 16'd1 << addr;
  endfunction
endpackage

// File: rtl/wb_queue2.sv
// wb_queue2: 2-entry write-back FIFO; head sits in slot 0, exposes per-entry valid/addr
module wb_queue2 #(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DW-1:0]       data_i,
  input  logic                pop_i,
  output logic                ready_o,
  output logic [AW-1:0]       head_addr_o,
  output logic [DW-1:0]       head_data_o,
  output logic [1:0]          ent_vld_o,
  output logic [1:0][AW-1:0]  ent_addr_o
);
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0][AW-1:0]  addr_q, addr_d;
  logic [1:0][DW-1:0]  data_q, data_d;
  logic                push, pop, slot;
  assign ready_o     = cnt_q < 2'(DEPTH);
  assign push        = valid_i & ready_o;
  assign pop         = pop_i & (cnt_q != 2'd0);
  // a push lands behind whatever survives this edge's pop
  assign slot        = cnt_q[0] & ~pop;
  assign head_addr_o = addr_q[0];
  assign head_data_o = data_q[0];
  assign ent_vld_o   = {cnt_q == 2'd2, cnt_q != 2'd0};
  assign ent_addr_o  = addr_q;
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      addr_d[0] = addr_q[1];
      data_d[0] = data_q[1];
    end
    if (push) begin
      addr_d[slot] = addr_i;
      data_d[slot] = data_i;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    cnt_q  <= rst ? cnt_d : 2'd0;
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between
// ALU (A) and load (B) write-back queues, with a pending-write mask for hazard stalls
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH:0]   a_addr,
  input  logic [DATA_WIDTH:0]   a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH:0]   b_addr,
  input  logic [DATA_WIDTH:0]   b_data,
  input  logic                  hold,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH:0]   wr_addr,
  output logic [DATA_WIDTH:0]   wr_data,
  output logic [REG_COUNT-1:0]  pending_mask,
  output logic                  idle
);
  logic [ADDR_WIDTH:0]        a_head_addr, b_head_addr, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH:0]        a_head_data, b_head_data, wr_data_q, wr_data_d;
  logic [1:0]                 a_vld, b_vld;
  logic [1:0][ADDR_WIDTH:0]   a_ent, b_ent;
  logic                       a_el, b_el, grant_a, grant_b;
  logic                       last_q, last_d, wr_enable_q;
  wb_queue2 #(.DW(DATA_WIDTH+1), .AW(ADDR_WIDTH+1), .DEPTH(DEPTH)) u_qa (
    .clk(clk), .rst(rst), .valid_i(a_valid), .addr_i(a_addr), .data_i(a_data),
    .pop_i(grant_a), .ready_o(a_ready), .head_addr_o(a_head_addr),
    .head_data_o(a_head_data), .ent_vld_o(a_vld), .ent_addr_o(a_ent)
  );
  wb_queue2 #(.DW(DATA_WIDTH+1), .AW(ADDR_WIDTH+1), .DEPTH(DEPTH)) u_qb (
    .clk(clk), .rst(rst), .valid_i(b_valid), .addr_i(b_addr), .data_i(b_data),
    .pop_i(grant_b), .ready_o(b_ready), .head_addr_o(b_head_addr),
    .head_data_o(b_head_data), .ent_vld_o(b_vld), .ent_addr_o(b_ent)
  );
  assign a_el      = a_vld[0] & ~hold;
  assign b_el      = b_vld[0] & ~hold;
  assign grant_a   = a_el & (~b_el | (last_q == REQ_B));
  assign grant_b   = b_el & ~grant_a;
  assign last_d    = grant_a ? REQ_A : grant_b ? REQ_B : last_q;
  assign wr_addr_d = grant_a ? a_head_addr : grant_b ? b_head_addr : wr_addr_q;
  assign wr_data_d = grant_a ? a_head_data : grant_b ? b_head_data : wr_data_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q      <= REQ_B;
      wr_enable_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      last_q      <= last_d;
      wr_enable_q <= grant_a | grant_b;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end
  assign wr_enable = wr_enable_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign idle      = ~a_vld[0] & ~b_vld[0] & ~wr_enable_q;
  always_comb begin
    pending_mask = wr_enable_q ? onehot16(wr_addr_q) : '0;
    for (int i = 0; i < 2; i++) begin
      pending_mask |= a_vld[i] ? onehot16(a_ent[i]) : '0;
      pending_mask |= b_vld[i] ? onehot16(b_ent[i]) : '0;
    end
  end
endmodule
